pipe_mem_responder: RTL and testbench
=====================================

PIPE_MEM_RESPONDER -- requirements
Module: pipe_mem_responder

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, giving the number of consecutive data grants allowed while an instruction request waits.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port imemREN, input, 1, the fetch request from IF; it is held until ihit.
REQ-005 The block SHALL have port imemaddr, input, word_t, the fetch address.
REQ-006 The block SHALL have port ihit, output, 1, a one-cycle fetch completion pulse.
REQ-007 The block SHALL have port imemload, output, word_t, fetched instruction data, registered.
REQ-008 The block SHALL have port dmemREN, input, 1, the load request from MEM.
REQ-009 The block SHALL have port dmemWEN, input, 1, the store request from MEM.
REQ-010 The block SHALL have port dmemaddr, input, word_t, the data address.
REQ-011 The block SHALL have port dmemstore, input, word_t, the store data.
REQ-012 The block SHALL have port dhit, output, 1, a one-cycle data completion pulse.
REQ-013 The block SHALL have port dmemload, output, word_t, load data, registered.
REQ-014 The block SHALL have port ramREN, output, 1, the RAM read strobe.
REQ-015 The block SHALL have port ramWEN, output, 1, the RAM write strobe.
REQ-016 The block SHALL have port ramaddr, output, word_t, the RAM address.
REQ-017 The block SHALL have port ramstore, output, word_t, the RAM write data.
REQ-018 The block SHALL have port ramload, input, word_t, the RAM read data.
REQ-019 The block SHALL have port ramstate, input, ramstate_t, one of FREE, BUSY, ACCESS, ERROR.

Function
REQ-020 The FSM SHALL have states IDLE, DGRANT, IGRANT and TURN.
REQ-021 In IDLE, a pending data request (dmemREN or dmemWEN) SHALL move the FSM to DGRANT, else imemREN SHALL move it to IGRANT, else the FSM SHALL stay in IDLE.
REQ-022 When both request types are pending and the starvation counter equals STARVE_MAX, IGRANT SHALL win instead of DGRANT.
REQ-023 The starvation counter SHALL increment on each DGRANT entry while imemREN is high, clear on IGRANT entry, and saturate at STARVE_MAX.
REQ-024 In DGRANT, ramaddr SHALL equal dmemaddr, ramstore SHALL equal dmemstore, ramWEN SHALL equal dmemWEN, and ramREN SHALL equal dmemREN and not dmemWEN (the store wins if both are asserted).
REQ-025 In IGRANT, ramaddr SHALL equal imemaddr, ramREN SHALL be 1 and ramWEN SHALL be 0.
REQ-026 In IDLE and TURN, ramREN and ramWEN SHALL be 0, and ramaddr and ramstore SHALL be 0.
REQ-027 In a grant state with ramstate=ACCESS, the FSM SHALL latch ramload into dmemload or imemload, pulse dhit or ihit high for exactly the next cycle, and go to TURN.
REQ-028 In a grant state, ramstate BUSY or FREE SHALL hold the state, and ERROR SHALL hold the state and re-present the same request (retry); the block SHALL have no timeout.
REQ-029 If the granted request deasserts before ACCESS, the FSM SHALL return to IDLE, produce no hit, and leave the load registers unchanged.
REQ-030 TURN SHALL last one cycle and then return to IDLE, so back-to-back accesses are separated by at least one idle RAM cycle.
REQ-031 Minimum latency SHALL be 3 cycles from request to hit: IDLE, then a grant state with ACCESS, then the hit cycle.
REQ-032 A store hit SHALL leave dmemload unchanged.
REQ-033 ihit and dhit SHALL never be asserted in the same cycle.

Reset
REQ-034 While RST=1 at a clock edge, the block SHALL enter IDLE, clear the starvation counter, clear ihit, dhit, imemload and dmemload to 0, and force all RAM outputs to 0 from that cycle on.
REQ-035 A reset in the middle of a transaction SHALL abandon the transaction with no hit.

Structure
REQ-036 The state enum (resp_state_t) SHALL reside in my_types_pkg, which SHALL import cpu_types_pkg; word_t and ramstate_t SHALL come from cpu_types_pkg.
REQ-037 The design SHALL be flat, with one registered FSM block and one combinational output/next-state block; no sub-module is needed.

Verification
REQ-038 A load with dmemREN=1, dmemaddr=0x40 and RAM BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF SHALL produce dhit on cycle 5 and dmemload=0xDEADBEEF.
REQ-039 A simultaneous fetch at 0x0 and store 0x1234 at 0x80 SHALL serve the store first (dhit with ramWEN seen), then give one TURN cycle, then serve the fetch (ihit).
REQ-040 With dmemREN held high continuously, imemREN high and STARVE_MAX=4, the 5th grant SHALL be IGRANT.
REQ-041 ramstate=ERROR twice then ACCESS SHALL keep the same ramaddr throughout and produce exactly one hit.
REQ-042 RST asserted during DGRANT SHALL produce no dhit, all RAM outputs 0 on the next cycle, and dmemload=0.
REQ-043 dmemREN dropped during BUSY SHALL produce a return to IDLE, no dhit and an unchanged dmemload.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: the machine word and the RAM handshake status.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/my_types_pkg.sv
// Types local to the memory-responder slice of the pipeline.
package my_types_pkg;
  import cpu_types_pkg::*;

  // Arbiter states: idle, data port granted, instruction port granted,
  // and a one-cycle bus turnaround after every completed access.
  typedef enum logic [1:0] {
    IDLE,
    DGRANT,
    IGRANT,
    TURN
  } resp_state_t;

endpackage

// File: rtl/pipe_mem_responder.sv
// pipe_mem_responder
//   Arbitrates the pipeline's instruction-fetch and data ports onto a
//   single RAM. Data requests have priority unless the fetch has been
//   passed over STARVE_MAX times in a row. Every completed access is
//   followed by one turnaround cycle with the RAM bus idle.
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   imemREN, imemaddr           fetch request (held until ihit) / address
//   ihit, imemload              fetch completion pulse / registered data
//   dmemREN, dmemWEN            load / store request
//   dmemaddr, dmemstore         data address / store data
//   dhit, dmemload              data completion pulse / registered load data
//   ramREN, ramWEN              RAM read / write strobes
//   ramaddr, ramstore, ramload  RAM address / write data / read data
//   ramstate                    RAM status (FREE, BUSY, ACCESS, ERROR)
module pipe_mem_responder
  import cpu_types_pkg::*;
  import my_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      imemREN,
  input  word_t     imemaddr,
  output logic      ihit,
  output word_t     imemload,
  input  logic      dmemREN,
  input  logic      dmemWEN,
  input  word_t     dmemaddr,
  input  word_t     dmemstore,
  output logic      dhit,
  output word_t     dmemload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  resp_state_t   state, stateNext;
  logic [CW-1:0] starveCnt, starveNext;
  logic          ihitNext, dhitNext;
  word_t         imemloadNext, dmemloadNext;
  logic          dReq;
  logic          starved;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      starveCnt <= '0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      imemload  <= '0;
      dmemload  <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveNext;
      ihit      <= ihitNext;
      dhit      <= dhitNext;
      imemload  <= imemloadNext;
      dmemload  <= dmemloadNext;
    end
  end

  always_comb begin
    stateNext    = state;
    starveNext   = starveCnt;
    ihitNext     = 1'b0;
    dhitNext     = 1'b0;
    imemloadNext = imemload;
    dmemloadNext = dmemload;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    dReq         = dmemREN | dmemWEN;
    starved      = imemREN && (starveCnt == STARVE_LIM);

    case (state)
      IDLE: begin
        if (dReq && !starved) begin
          stateNext = DGRANT;
          // Count data grants taken while a fetch is waiting; saturates.
          if (imemREN && (starveCnt != STARVE_LIM))
            starveNext = starveCnt + CW'(1);
        end else if (imemREN) begin
          stateNext  = IGRANT;
          starveNext = '0;
        end
      end

      DGRANT: begin
        ramaddr  = dmemaddr;
        ramstore = dmemstore;
        ramWEN   = dmemWEN;
        ramREN   = dmemREN & ~dmemWEN;
        // A withdrawn request is abandoned even if the RAM completes.
        if (!dReq) begin
          stateNext = IDLE;
        end else if (ramstate == ACCESS) begin
          dhitNext  = 1'b1;
          stateNext = TURN;
          if (!dmemWEN)
            dmemloadNext = ramload;
        end
      end

      IGRANT: begin
        ramaddr = imemaddr;
        ramREN  = 1'b1;
        if (!imemREN) begin
          stateNext = IDLE;
        end else if (ramstate == ACCESS) begin
          ihitNext     = 1'b1;
          imemloadNext = ramload;
          stateNext    = TURN;
        end
      end

      TURN:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_mem_responder.sv
module tb_pipe_mem_responder;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      imemREN;
  word_t     imemaddr;
  logic      ihit;
  word_t     imemload;
  logic      dmemREN, dmemWEN;
  word_t     dmemaddr, dmemstore;
  logic      dhit;
  word_t     dmemload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  int errors = 0;
  int checks = 0;

  pipe_mem_responder #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; dmemREN = 1'b1; dmemWEN = 1'b0;
    dmemaddr = 32'h44; dmemstore = 32'h99; ramload = 32'h12345678; ramstate = ACCESS;
    tick; tick;
    checks++; if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin errors++;
      $display("FAIL reset_strobes: got %b expected 0000", {ramREN, ramWEN, ihit, dhit}); end
    checks++; if (ramaddr !== 32'h0) begin errors++;
      $display("FAIL reset_ramaddr: got %h expected 00000000", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin errors++;
      $display("FAIL reset_ramstore: got %h expected 00000000", ramstore); end
    checks++; if (imemload !== 32'h0 || dmemload !== 32'h0) begin errors++;
      $display("FAIL reset_loads: got %h/%h expected 0/0", imemload, dmemload); end
    dmemREN = 1'b0; ramstate = FREE; ramload = '0;
    RST = 1'b0;
    tick;
  endtask

  task automatic test_load_latency;
    dmemREN = 1'b1; dmemaddr = 32'h40; ramstate = BUSY; #1;
    checks++; if (ramREN !== 1'b0) begin errors++;
      $display("FAIL load_c1_idle: got ramREN=%b expected 0", ramREN); end
    tick; // cycle 2, BUSY
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin errors++;
      $display("FAIL load_c2_grant: got REN=%b WEN=%b addr=%h expected 1 0 00000040", ramREN, ramWEN, ramaddr); end
    tick; // cycle 3, BUSY
    checks++; if (dhit !== 1'b0 || ramREN !== 1'b1) begin errors++;
      $display("FAIL load_c3_busy: got dhit=%b REN=%b expected 0 1", dhit, ramREN); end
    tick; // cycle 4, ACCESS
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    checks++; if (dhit !== 1'b0 || ramaddr !== 32'h40) begin errors++;
      $display("FAIL load_c4_access: got dhit=%b addr=%h expected 0 00000040", dhit, ramaddr); end
    tick; // cycle 5, hit
    checks++; if (dhit !== 1'b1 || ihit !== 1'b0) begin errors++;
      $display("FAIL load_c5_dhit: got dhit=%b ihit=%b expected 1 0", dhit, ihit); end
    checks++; if (dmemload !== 32'hDEADBEEF) begin errors++;
      $display("FAIL load_data: got %h expected deadbeef", dmemload); end
    checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin errors++;
      $display("FAIL load_turn_idle_bus: got REN=%b addr=%h expected 0 00000000", ramREN, ramaddr); end
    dmemREN = 1'b0; ramstate = FREE;
    tick;
    checks++; if (dhit !== 1'b0) begin errors++;
      $display("FAIL load_dhit_single: got %b expected 0", dhit); end
  endtask

  task automatic test_back_to_back;
    imemREN = 1'b1; imemaddr = 32'h0; dmemWEN = 1'b1; dmemaddr = 32'h80;
    dmemstore = 32'h1234; ramstate = ACCESS; ramload = 32'hBAD0BAD0; #1;
    checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin errors++;
      $display("FAIL b2b_idle: got REN=%b WEN=%b expected 0 0", ramREN, ramWEN); end
    tick; // store granted first
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'h1234) begin errors++;
      $display("FAIL b2b_store_grant: got WEN=%b REN=%b addr=%h data=%h expected 1 0 00000080 00001234", ramWEN, ramREN, ramaddr, ramstore); end
    tick; // TURN with dhit
    checks++; if (dhit !== 1'b1 || ihit !== 1'b0) begin errors++;
      $display("FAIL b2b_dhit: got dhit=%b ihit=%b expected 1 0", dhit, ihit); end
    checks++; if (dmemload !== 32'hDEADBEEF) begin errors++;
      $display("FAIL b2b_store_keeps_load: got %h expected deadbeef", dmemload); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++;
      $display("FAIL b2b_turn_bus: got REN=%b WEN=%b addr=%h data=%h expected all 0", ramREN, ramWEN, ramaddr, ramstore); end
    dmemWEN = 1'b0; ramload = 32'h8C220004;
    tick; // IDLE
    checks++; if (ramREN !== 1'b0 || dhit !== 1'b0 || ihit !== 1'b0) begin errors++;
      $display("FAIL b2b_idle_gap: got REN=%b dhit=%b ihit=%b expected 0 0 0", ramREN, dhit, ihit); end
    tick; // IGRANT
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin errors++;
      $display("FAIL b2b_fetch_grant: got REN=%b WEN=%b addr=%h expected 1 0 00000000", ramREN, ramWEN, ramaddr); end
    tick; // ihit
    checks++; if (ihit !== 1'b1 || dhit !== 1'b0 || imemload !== 32'h8C220004) begin errors++;
      $display("FAIL b2b_ihit: got ihit=%b dhit=%b data=%h expected 1 0 8c220004", ihit, dhit, imemload); end
    imemREN = 1'b0;
    tick;
    checks++; if (ihit !== 1'b0) begin errors++;
      $display("FAIL b2b_ihit_single: got %b expected 0", ihit); end
  endtask

  task automatic test_starvation;
    bit grantI [0:7];
    int nGr = 0;
    bit bothHit = 1'b0;
    dmemREN = 1'b1; imemREN = 1'b1; imemaddr = 32'h100; dmemaddr = 32'h200;
    ramstate = ACCESS; ramload = 32'hCAFE0000;
    for (int c = 0; c < 40 && nGr < 5; c++) begin
      tick;
      if (ihit && dhit) bothHit = 1'b1;
      if (ramREN) begin
        grantI[nGr] = (ramaddr == 32'h100);
        nGr++;
      end
    end
    checks++; if (nGr !== 5) begin errors++;
      $display("FAIL starve_grant_count: got %0d grants expected 5 within budget", nGr); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (grantI[i] !== 1'b0) begin errors++;
        $display("FAIL starve_grant%0d_kind: got IGRANT expected DGRANT", i + 1); end
    end
    checks++; if (grantI[4] !== 1'b1) begin errors++;
      $display("FAIL starve_grant5_kind: got DGRANT expected IGRANT"); end
    tick;
    checks++; if (ihit !== 1'b1 || dhit !== 1'b0 || imemload !== 32'hCAFE0000) begin errors++;
      $display("FAIL starve_ihit: got ihit=%b dhit=%b data=%h expected 1 0 cafe0000", ihit, dhit, imemload); end
    checks++; if (bothHit !== 1'b0) begin errors++;
      $display("FAIL starve_hit_exclusive: got both hits together expected never"); end
    dmemREN = 1'b0; imemREN = 1'b0; ramstate = FREE;
    tick; tick;
  endtask

  task automatic test_error_retry;
    int hits = 0;
    dmemREN = 1'b1; dmemaddr = 32'h300; ramstate = ERROR; ramload = 32'h77777777;
    tick; hits += int'(dhit);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++;
      $display("FAIL err_retry1: got REN=%b addr=%h expected 1 00000300", ramREN, ramaddr); end
    tick; hits += int'(dhit);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++;
      $display("FAIL err_retry2: got REN=%b addr=%h expected 1 00000300", ramREN, ramaddr); end
    tick;
    ramstate = ACCESS; ramload = 32'h0F0F0F0F; #1;
    hits += int'(dhit);
    checks++; if (ramaddr !== 32'h300) begin errors++;
      $display("FAIL err_access_addr: got %h expected 00000300", ramaddr); end
    tick; hits += int'(dhit);
    dmemREN = 1'b0; ramstate = FREE;
    tick; hits += int'(dhit);
    tick; hits += int'(dhit);
    checks++; if (hits !== 1) begin errors++;
      $display("FAIL err_hit_count: got %0d expected 1", hits); end
    checks++; if (dmemload !== 32'h0F0F0F0F) begin errors++;
      $display("FAIL err_load_data: got %h expected 0f0f0f0f", dmemload); end
  endtask

  task automatic test_abandon;
    dmemREN = 1'b1; dmemaddr = 32'h400; ramstate = BUSY; ramload = 32'h11111111;
    tick;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h400) begin errors++;
      $display("FAIL abandon_grant: got REN=%b addr=%h expected 1 00000400", ramREN, ramaddr); end
    tick;
    dmemREN = 1'b0;
    tick;
    checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dhit !== 1'b0) begin errors++;
      $display("FAIL abandon_idle: got REN=%b addr=%h dhit=%b expected 0 00000000 0", ramREN, ramaddr, dhit); end
    tick;
    checks++; if (dhit !== 1'b0 || dmemload !== 32'h0F0F0F0F) begin errors++;
      $display("FAIL abandon_no_hit: got dhit=%b data=%h expected 0 0f0f0f0f", dhit, dmemload); end
  endtask

  task automatic test_reset_mid;
    dmemREN = 1'b1; dmemaddr = 32'h500; dmemstore = 32'hA5A5; ramstate = BUSY;
    tick;
    checks++; if (ramREN !== 1'b1) begin errors++;
      $display("FAIL rstmid_grant: got REN=%b expected 1", ramREN); end
    RST = 1'b1; ramstate = ACCESS; ramload = 32'h55AA55AA;
    tick;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++;
      $display("FAIL rstmid_bus: got REN=%b WEN=%b addr=%h data=%h expected all 0", ramREN, ramWEN, ramaddr, ramstore); end
    checks++; if (dhit !== 1'b0 || dmemload !== 32'h0 || imemload !== 32'h0) begin errors++;
      $display("FAIL rstmid_regs: got dhit=%b dload=%h iload=%h expected 0 0 0", dhit, dmemload, imemload); end
    RST = 1'b0; dmemREN = 1'b0; ramstate = FREE;
    tick;
    checks++; if (dhit !== 1'b0 || dmemload !== 32'h0) begin errors++;
      $display("FAIL rstmid_after: got dhit=%b data=%h expected 0 00000000", dhit, dmemload); end
  endtask

  initial begin
    test_reset;
    test_load_latency;
    test_back_to_back;
    test_starvation;
    test_error_retry;
    test_abandon;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
